// File: rtl/cell_scan_timing.sv
// rtl/cell_scan_timing.sv - parametrised raster scan generator with text-cell coordinates; optional blink phase via CELL_SCAN_BLINK_EN
module cell_scan_timing #(
  parameter int   H_ACTIVE     = 640,
  parameter int   H_FP         = 16,
  parameter int   H_SYNC       = 96,
  parameter int   H_BP         = 48,
  parameter int   V_ACTIVE     = 480,
  parameter int   V_FP         = 10,
  parameter int   V_SYNC       = 2,
  parameter int   V_BP         = 33,
  parameter int   HSZ          = 10,
  parameter int   VSZ          = 10,
  parameter int   CELL_W       = 8,
  parameter int   CELL_H       = 8,
  parameter int   COL_W        = 7,
  parameter int   ROW_W        = 6,
  parameter logic HS_POL       = 1'b0,
  parameter logic VS_POL       = 1'b0,
  parameter int   BLINK_FRAMES = 30
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      i_ce,
  output logic [HSZ-1:0]            o_hcount,
  output logic [VSZ-1:0]            o_vcount,
  output logic                      o_de,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic [$clog2(CELL_W)-1:0] o_cell_x,
  output logic [$clog2(CELL_H)-1:0] o_cell_y,
  output logic [COL_W-1:0]          o_text_col,
  output logic [ROW_W-1:0]          o_text_row,
  output logic                      o_line_start,
  output logic                      o_frame_start,
  output logic                      o_blink
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;
  localparam int CX_W     = $clog2(CELL_W);
  localparam int CY_W     = $clog2(CELL_H);

  logic [HSZ-1:0]   h_q, h_d;
  logic [VSZ-1:0]   v_q, v_d;
  logic [CX_W-1:0]  cx_q, cx_d;
  logic [CY_W-1:0]  cy_q, cy_d;
  logic [COL_W-1:0] tc_q, tc_d;
  logic [ROW_W-1:0] tr_q, tr_d;
  logic             h_wrap, v_wrap;
  logic             de_c, hs_c, vs_c, ls_c, fs_c;

  logic [HSZ-1:0]   hcount_q;
  logic [VSZ-1:0]   vcount_q;
  logic [CX_W-1:0]  cell_x_q;
  logic [CY_W-1:0]  cell_y_q;
  logic [COL_W-1:0] text_col_q;
  logic [ROW_W-1:0] text_row_q;
  logic             de_q, hsync_q, vsync_q, line_start_q, frame_start_q;

  // Next scan position; cell counters track the raster by counting, never by dividing
  always_comb begin
    h_wrap = (int'(h_q) == H_TOTAL - 1);
    v_wrap = (int'(v_q) == V_TOTAL - 1);
    h_d    = h_wrap ? '0 : h_q + HSZ'(1);
    v_d    = v_q;
    cx_d   = cx_q;
    tc_d   = tc_q;
    cy_d   = cy_q;
    tr_d   = tr_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + VSZ'(1);
    end
    // The following pixel is past the active width (or on the next line): park at cell 0
    if (int'(h_q) >= H_ACTIVE - 1) begin
      cx_d = '0;
      tc_d = '0;
    end else if (int'(cx_q) == CELL_W - 1) begin
      cx_d = '0;
      tc_d = tc_q + COL_W'(1);
    end else begin
      cx_d = cx_q + CX_W'(1);
    end
    // Glyph row steps once per line; the following line being blank or a new frame parks it
    if (h_wrap) begin
      if (int'(v_q) >= V_ACTIVE - 1) begin
        cy_d = '0;
        tr_d = '0;
      end else if (int'(cy_q) == CELL_H - 1) begin
        cy_d = '0;
        tr_d = tr_q + ROW_W'(1);
      end else begin
        cy_d = cy_q + CY_W'(1);
      end
    end
  end

  // Decode of the pixel currently held in the scan state
  always_comb begin
    de_c = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    hs_c = ((int'(h_q) >= HS_START) && (int'(h_q) < HS_STOP)) ? HS_POL : ~HS_POL;
    vs_c = ((int'(v_q) >= VS_START) && (int'(v_q) < VS_STOP)) ? VS_POL : ~VS_POL;
    ls_c = (h_q == '0);
    fs_c = (h_q == '0) && (v_q == '0);
  end

  // Scan state advances one pixel per enabled cycle
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      h_q  <= '0;
      v_q  <= '0;
      cx_q <= '0;
      cy_q <= '0;
      tc_q <= '0;
      tr_q <= '0;
    end else if (i_ce) begin
      h_q  <= h_d;
      v_q  <= v_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      tc_q <= tc_d;
      tr_q <= tr_d;
    end
  end

  // Single output stage: every output describes the same pixel
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      cell_x_q      <= '0;
      cell_y_q      <= '0;
      text_col_q    <= '0;
      text_row_q    <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (i_ce) begin
      hcount_q      <= h_q;
      vcount_q      <= v_q;
      cell_x_q      <= cx_q;
      cell_y_q      <= cy_q;
      text_col_q    <= tc_q;
      text_row_q    <= tr_q;
      de_q          <= de_c;
      hsync_q       <= hs_c;
      vsync_q       <= vs_c;
      line_start_q  <= ls_c;
      frame_start_q <= fs_c;
    end
  end

  assign o_hcount      = hcount_q;
  assign o_vcount      = vcount_q;
  assign o_cell_x      = cell_x_q;
  assign o_cell_y      = cell_y_q;
  assign o_text_col    = text_col_q;
  assign o_text_row    = text_row_q;
  assign o_de          = de_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;

`ifdef CELL_SCAN_BLINK_EN
  logic [7:0] fcnt_q;
  logic       blink_state_q;
  logic       blink_q;

  // Frame counter toggles the blink phase every BLINK_FRAMES frame wraps
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      fcnt_q        <= '0;
      blink_state_q <= 1'b0;
    end else if (i_ce && h_wrap && v_wrap) begin
      if (fcnt_q == 8'(BLINK_FRAMES - 1)) begin
        fcnt_q        <= '0;
        blink_state_q <= ~blink_state_q;
      end else begin
        fcnt_q <= fcnt_q + 8'd1;
      end
    end
  end

  // Blink rides the output stage so it flips on the frame_start pixel
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      blink_q <= 1'b0;
    end else if (i_ce) begin
      blink_q <= blink_state_q;
    end
  end

  assign o_blink = blink_q;
`else
  // BLINK_FRAMES only matters when the blink counter is built in
  assign o_blink = 1'b0 && (BLINK_FRAMES > 0);
`endif

endmodule

// File: tb/tb_cell_scan_timing.sv
// tb/tb_cell_scan_timing.sv - directed bench for cell_scan_timing, default and small timings
module tb_cell_scan_timing;

  localparam int SH_TOT = 28;
  localparam int SV_TOT = 16;
  localparam int SFRAME = SH_TOT * SV_TOT;

  logic clk = 1'b0;
  logic rstn;
  logic ce;

  always #5 clk = ~clk;

  logic [9:0] d_hcount, s_hcount;
  logic [9:0] d_vcount, s_vcount;
  logic       d_de, d_hsync, d_vsync, d_ls, d_fs, d_blink;
  logic       s_de, s_hsync, s_vsync, s_ls, s_fs, s_blink;
  logic [2:0] d_cx, d_cy, s_cx, s_cy;
  logic [6:0] d_tc, s_tc;
  logic [5:0] d_tr, s_tr;

  cell_scan_timing u_def (
    .clk_i(clk), .rstn_i(rstn), .i_ce(ce),
    .o_hcount(d_hcount), .o_vcount(d_vcount), .o_de(d_de),
    .o_hsync(d_hsync), .o_vsync(d_vsync),
    .o_cell_x(d_cx), .o_cell_y(d_cy), .o_text_col(d_tc), .o_text_row(d_tr),
    .o_line_start(d_ls), .o_frame_start(d_fs), .o_blink(d_blink)
  );

  cell_scan_timing #(
    .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .BLINK_FRAMES(2)
  ) u_sml (
    .clk_i(clk), .rstn_i(rstn), .i_ce(ce),
    .o_hcount(s_hcount), .o_vcount(s_vcount), .o_de(s_de),
    .o_hsync(s_hsync), .o_vsync(s_vsync),
    .o_cell_x(s_cx), .o_cell_y(s_cy), .o_text_col(s_tc), .o_text_row(s_tr),
    .o_line_start(s_ls), .o_frame_start(s_fs), .o_blink(s_blink)
  );

  int checks   = 0;
  int failures = 0;
  int n        = 0;
  int cur      = 0;

  function automatic logic [43:0] sml_actual();
    return {s_hcount, s_vcount, s_cx, s_cy, s_tc, s_tr, s_de, s_hsync, s_vsync, s_ls, s_fs};
  endfunction

  function automatic logic [43:0] sml_expect(input int p);
    int ph, pv;
    logic [43:0] e;
    ph = p % SH_TOT;
    pv = (p / SH_TOT) % SV_TOT;
    e = {10'(ph), 10'(pv),
         3'((ph < 20) ? ph % 8 : 0), 3'((pv < 12) ? pv % 8 : 0),
         7'((ph < 20) ? ph / 8 : 0), 6'((pv < 12) ? pv / 8 : 0),
         (ph < 20) && (pv < 12), !(ph >= 22 && ph < 25), !(pv >= 13 && pv < 15),
         ph == 0, (ph == 0) && (pv == 0)};
    return e;
  endfunction

  task automatic tick(input logic c);
    ce = c;
    @(posedge clk);
    #1;
    if (c && rstn) begin
      cur = n;
      n   = n + 1;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    ce   = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({d_hcount, d_vcount, d_cx, d_cy, d_tc, d_tr} !== 39'd0) begin
      failures++;
      $display("FAIL reset_def_counters actual=%h expected=0", {d_hcount, d_vcount, d_cx, d_cy, d_tc, d_tr});
    end
    checks++;
    if ({d_de, d_hsync, d_vsync, d_ls, d_fs, d_blink} !== 6'b011000) begin
      failures++;
      $display("FAIL reset_def_flags actual=%b expected=011000", {d_de, d_hsync, d_vsync, d_ls, d_fs, d_blink});
    end
    checks++;
    if ({sml_actual(), s_blink} !== {39'd0, 6'b011000}) begin
      failures++;
      $display("FAIL reset_sml actual=%h expected=%h", {sml_actual(), s_blink}, {39'd0, 6'b011000});
    end
  endtask

  task automatic test_first_pixel;
    ce = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    tick(1'b1);
    checks++;
    if ({d_hcount, d_vcount, d_de, d_ls, d_fs, d_hsync, d_vsync} !== {20'd0, 5'b11111}) begin
      failures++;
      $display("FAIL first_pixel_def actual=%h expected=%h", {d_hcount, d_vcount, d_de, d_ls, d_fs, d_hsync, d_vsync}, {20'd0, 5'b11111});
    end
    checks++;
    if (sml_actual() !== sml_expect(0)) begin
      failures++;
      $display("FAIL first_pixel_sml actual=%h expected=%h", sml_actual(), sml_expect(0));
    end
  endtask

  task automatic test_default_timing;
    int dh, dv;
    for (int i = 0; i < 11 * 800 + 2; i++) begin
      tick(1'b1);
      dh = cur % 800;
      dv = cur / 800;
      checks++;
      if ({d_hcount, d_vcount, d_ls, d_vsync} !== {10'(dh), 10'(dv), dh == 0, 1'b1}) begin
        failures++;
        $display("FAIL def_raster n=%0d actual=%h expected=%h", cur, {d_hcount, d_vcount, d_ls, d_vsync}, {10'(dh), 10'(dv), dh == 0, 1'b1});
      end
      if (dv == 10 && dh == 17) begin
        checks++;
        if ({d_cx, d_tc, d_cy, d_tr, d_de} !== {3'd1, 7'd2, 3'd2, 6'd1, 1'b1}) begin
          failures++;
          $display("FAIL def_cell_17_10 actual=%h expected=%h", {d_cx, d_tc, d_cy, d_tr, d_de}, {3'd1, 7'd2, 3'd2, 6'd1, 1'b1});
        end
      end
      if (dv == 10 && dh == 640) begin
        checks++;
        if ({d_cx, d_tc, d_de} !== {3'd0, 7'd0, 1'b0}) begin
          failures++;
          $display("FAIL def_cell_640 actual=%h expected=0", {d_cx, d_tc, d_de});
        end
      end
      if (dv == 10 && (dh == 655 || dh == 656 || dh == 751 || dh == 752)) begin
        checks++;
        if (d_hsync !== ((dh == 655) || (dh == 752))) begin
          failures++;
          $display("FAIL def_hsync h=%0d actual=%b expected=%b", dh, d_hsync, (dh == 655) || (dh == 752));
        end
      end
    end
  endtask

  task automatic test_small_cells;
    int ph, pv;
    for (int i = 0; i < SFRAME; i++) begin
      tick(1'b1);
      ph = cur % SH_TOT;
      pv = (cur / SH_TOT) % SV_TOT;
      checks++;
      if (sml_actual() !== sml_expect(cur)) begin
        failures++;
        $display("FAIL sml_scan n=%0d actual=%h expected=%h", cur, sml_actual(), sml_expect(cur));
      end
      if (ph == 19) begin
        checks++;
        if ({s_cx, s_tc} !== {3'd3, 7'd2}) begin
          failures++;
          $display("FAIL sml_last_hcell actual=%h expected=%h", {s_cx, s_tc}, {3'd3, 7'd2});
        end
      end
      if (pv == 11 && ph == 0) begin
        checks++;
        if ({s_cy, s_tr} !== {3'd3, 6'd1}) begin
          failures++;
          $display("FAIL sml_last_vcell actual=%h expected=%h", {s_cy, s_tr}, {3'd3, 6'd1});
        end
      end
    end
  endtask

  task automatic test_ce_gaps;
    logic [43:0] prev;
    logic        c;
    prev = sml_actual();
    for (int i = 0; i < 80; i++) begin
      c = (i % 4 == 0) || (i % 4 == 3);
      tick(c);
      checks++;
      if (c) begin
        if (sml_actual() !== sml_expect(cur)) begin
          failures++;
          $display("FAIL ce_advance i=%0d actual=%h expected=%h", i, sml_actual(), sml_expect(cur));
        end
      end else if (sml_actual() !== prev) begin
        failures++;
        $display("FAIL ce_hold i=%0d actual=%h expected=%h", i, sml_actual(), prev);
      end
      prev = sml_actual();
    end
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 1'b0;
    for (int i = 0; i < SFRAME && !found; i++) begin
      tick(1'b1);
      if (s_hcount == 10'd10 && s_vcount == 10'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid_reach actual=%0d/%0d expected=10/5", s_hcount, s_vcount);
    end
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if ({sml_actual(), s_blink} !== {39'd0, 6'b011000}) begin
      failures++;
      $display("FAIL reset_async actual=%h expected=%h", {sml_actual(), s_blink}, {39'd0, 6'b011000});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      checks++;
      if ({sml_actual(), s_blink, d_hcount, d_vcount} !== {39'd0, 6'b011000, 20'd0}) begin
        failures++;
        $display("FAIL reset_hold i=%0d actual=%h", i, {sml_actual(), s_blink, d_hcount, d_vcount});
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1);
      checks++;
      if (sml_actual() !== sml_expect(cur)) begin
        failures++;
        $display("FAIL reset_restart n=%0d actual=%h expected=%h", cur, sml_actual(), sml_expect(cur));
      end
    end
  endtask

  task automatic test_blink;
    int   f;
    logic eb;
    while (n < 5 * SFRAME + 2) begin
      tick(1'b1);
      f = cur / SFRAME;
`ifdef CELL_SCAN_BLINK_EN
      eb = ((f / 2) % 2) == 1;
`else
      eb = 1'b0;
`endif
      checks++;
      if ({s_blink, s_fs} !== {eb, (cur % SFRAME) == 0}) begin
        failures++;
        $display("FAIL blink n=%0d frame=%0d actual=%b expected=%b", cur, f, {s_blink, s_fs}, {eb, (cur % SFRAME) == 0});
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    ce   = 1'b0;
    test_reset;
    test_first_pixel;
    test_default_timing;
    test_small_cells;
    test_ce_gaps;
    test_reset_mid;
    test_blink;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
